// File: rtl/rr_stream_mux.sv
// N-channel round-robin stream mux with a registered valid/ready output stage.
// Define RR_STREAM_MUX_PKT_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module rr_stream_mux #(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  localparam int unsigned NU = N;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load;
  logic             any;
  logic             xfer;
  logic             advance;
  logic [N-1:0]     elig;
  logic [SEL_W-1:0] grant;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e            lock_q,  lock_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic             last_q,  last_d;
  logic             grant_last;

  // While locked only the packet owner is eligible for arbitration.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      elig[i] = in_valid[i] && (lock_q == UNLOCKED || owner_q == SEL_W'(i));
    end
  end

  assign grant_last = in_last[grant];
  assign advance    = grant_last;

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    last_d  = last_q;
    if (xfer) begin
      last_d = grant_last;
      case (lock_q)
        UNLOCKED: begin
          if (!grant_last) begin
            lock_d  = LOCKED;
            owner_d = grant;
          end
        end
        LOCKED: begin
          if (grant_last) lock_d = UNLOCKED;
        end
        default: lock_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q  <= UNLOCKED;
      owner_q <= '0;
      last_q  <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign out_last = last_q;
`else
  assign elig    = in_valid;
  assign advance = 1'b1;
`endif

  // First eligible channel at or after ptr, wrapping past N-1 back to 0.
  always_comb begin
    logic found;
    found = 1'b0;
    grant = '0;
    any   = |elig;
    for (int unsigned k = 0; k < NU; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= NU) idx = idx - NU;
      if (!found && elig[idx]) begin
        found = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

  assign load = !out_valid_q || out_ready;
  assign xfer = load && any;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      in_ready[i] = xfer && (grant == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant*W +: W];
      out_sel_d   = grant;
      if (advance) ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed plus randomized bench for rr_stream_mux with a round-robin reference model.
module tb_rr_stream_mux;
  localparam int N     = 4;
  localparam int W     = 4;
  localparam int SEL_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]     in_last;
  logic             out_last;
`endif

  always #5 clk = ~clk;

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic [W-1:0]     data;
    logic [SEL_W-1:0] sel;
    logic             last;
  } beat_t;

  beat_t       sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned mptr     = 0;
  logic        mvalid   = 1'b0;
  beat_t       mout     = '0;
  logic        mlocked  = 1'b0;
  int unsigned mowner   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic last_of(input int unsigned ch);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    return in_last[ch];
`else
    return ch >= 0;
`endif
  endfunction

  // One clock: check in_ready against the model, push expected beat, advance, check outputs.
  task automatic cycle();
    int unsigned g;
    logic        found;
    logic        ld;
    logic        hs;
    logic [N-1:0] exp_rdy;
    beat_t       b;
    #1;
    g = 0; found = 1'b0; hs = 1'b0; exp_rdy = '0; ld = 1'b0; b = '0;
    if (!rst) begin
      ld = !mvalid || out_ready;
      for (int k = 0; k < N; k++) begin
        int unsigned c;
        c = (mptr + k) % N;
        if (!found && in_valid[c] && (!mlocked || c == mowner)) begin
          found = 1'b1;
          g = c;
        end
      end
      if (ld && found) begin
        exp_rdy[g] = 1'b1;
        hs = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (hs) begin
        b.data = in_data[g*W +: W];
        b.sel  = SEL_W'(g);
        b.last = last_of(g);
        sb.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mvalid = 1'b0; mout = '0; mptr = 0; mlocked = 1'b0; mowner = 0;
      sb.delete();
    end else if (hs) begin
      if (!mlocked && !b.last) begin
        mlocked = 1'b1;
        mowner  = g;
      end else if (mlocked && b.last) begin
        mlocked = 1'b0;
      end
      if (b.last) mptr = (g + 1) % N;
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'(0), 32'(1));
      end else begin
        mout = sb.pop_front();
      end
      mvalid = 1'b1;
    end else if (ld) begin
      mvalid = 1'b0;
    end
    check("out_valid", 32'(out_valid), 32'(mvalid));
    check("out_data",  32'(out_data),  32'(mout.data));
    check("out_sel",   32'(out_sel),   32'(mout.sel));
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    check("out_last",  32'(out_last),  32'(mout.last));
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    in_last = '1;
`endif
    // Reset then idle
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Full rotation
    in_data = {4'hD, 4'hC, 4'hB, 4'hA};
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) cycle();

    // Move ptr to 3, then sparse wrap-around
    in_valid = 4'b0100; cycle();
    in_valid = 4'b0101; cycle(); cycle();
    in_valid = 4'b0000; cycle();

    // Backpressure holding 'h5
    in_data = {4'h5, 4'h7, 4'h6, 4'h9};
    in_valid = 4'b1000; cycle();
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b1; cycle(); cycle();

    // Reset during a stall
    out_ready = 1'b0; cycle();
    rst = 1'b1; cycle();
    rst = 1'b0; out_ready = 1'b1; in_valid = 4'b1111; cycle();
    in_valid = 4'b0000; cycle(); cycle();

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // Packet lock: channel 1 sends 3 beats while channel 0 stays valid
    rst = 1'b1; cycle();
    rst = 1'b0;
    in_data = {4'h4, 4'h3, 4'h2, 4'h1};
    in_valid = 4'b0010; in_last = 4'b1101; cycle();
    in_valid = 4'b0011; cycle();
    in_last = 4'b1111; cycle();
    cycle();
    in_valid = 4'b0000; cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      in_last   = 4'($urandom_range(0, 15));
`endif
      cycle();
    end

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit stream multiplexer with round-robin arbitration and a registered valid/ready output stage.
- Next step up from the fixed 4:1 combinational muxes: selection is made by a fair arbiter rather than a `sel` input.
- Sits between several producer streams and one consumer. Output carries the winning data and its source index.

Parameters:
- N, 4, number of input channels (≥1)
- W, 4, data width per channel
- SEL_W, (N > 1 ? $clog2(N) : 1), width of source index (derived; do not override)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  N  per-channel valid
- in_data  input  N*W  packed channel data, channel i at [i*W +: W]
- in_ready  output  N  per-channel ready (combinational)
- out_valid  output  1  registered output valid
- out_data  output  W  registered output data
- out_sel  output  SEL_W  registered index of the channel that supplied out_data
- out_ready  input  1  consumer ready

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. This also applies mid-operation: a held beat is dropped.
- load = !out_valid || out_ready. The output register may accept a new beat this cycle.
- Arbitration (combinational):
  - grant = first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - any = |in_valid.
  - in_ready[i] = load && any && (grant==i). At most one bit of in_ready is high.
  - in_ready depends only on in_valid, ptr, out_valid and out_ready. in_ready never depends on in_data.
- Transfer: channel i transfers when in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
  - ptr <= (i==N-1) ? 0 : i+1
- Drain with no new beat: if load && !any, then out_valid <= 0. out_data and out_sel hold their last values.
- Stall: while out_valid && !out_ready, out_valid, out_data and out_sel hold stable. All in_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle when out_ready=1 continuously.
- Simultaneous drain and refill (out_valid=1, out_ready=1, any=1): new beat loads on the same edge. No bubble.
- Fairness: with all N channels continuously valid, grants go ptr, ptr+1, … in strict rotation. Each channel is served once every N beats.
- Inputs may deassert in_valid without a handshake. Arbitration simply re-evaluates. ptr changes only on a transfer.
- N=1: degenerates to a one-stage pipeline register. out_sel is always 0.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN.
- When defined, the block adds:
  - input in_last [N]
  - output out_last [1], registered alongside out_data, reset 0
- FSM states:
  - UNLOCKED: normal arbitration.
  - LOCKED(owner): only owner may be granted; other in_ready=0 even if valid.
- Transitions:
  - UNLOCKED → LOCKED(i) on a transfer from i with in_last[i]=0.
  - LOCKED → UNLOCKED on a transfer from owner with in_last=1.
  - A single-beat packet (last=1 on first beat) stays UNLOCKED.
- ptr advances only on transfers with in_last=1.
- Reset forces UNLOCKED.
- When not defined: no in_last/out_last ports, no lock state, and ptr advances on every transfer.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all in_valid=0 → out_valid=0, out_data=0, out_sel=0, in_ready=0000.
- Rotation, N=4, W=4: in_data = {3:'hD, 2:'hC, 1:'hB, 0:'hA}, in_valid=1111, out_ready=1 for 6 cycles → out_data A,B,C,D,A,B and out_sel 0,1,2,3,0,1, one beat per cycle after a 1-cycle latency.
- Sparse/wrap: ptr=3, in_valid=0101 → channel 0 granted (wrap), out_sel=0. Next cycle, still 0101 → channel 2 granted, out_sel=2.
- Backpressure: out_valid=1 with out_data='h5, out_ready=0 for 3 cycles, in_valid=1111 → out_data stays 'h5, in_ready=0000. Raise out_ready → next beat loads on the same edge.
- Reset mid-stall: out_valid=1 and out_ready=0, assert rst one cycle → out_valid=0, ptr=0. The next grant with in_valid=1111 goes to channel 0.
- With RR_STREAM_MUX_PKT_LOCK_EN: channel 1 sends 3 beats (last on the 3rd) while channel 0 stays valid → out_sel 1,1,1 with out_last 0,0,1, then out_sel=2 or the next valid channel after 1. Channel 0 gets in_ready=0 throughout the packet.
